// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between the MEM stage and data memory.
// Sizes accesses from funct3, generates byte enables and lane-replicated
// store data, extends load data, traps misaligned/illegal accesses and runs a
// req/gnt/rvalid handshake with variable latency.
// Optional: define RISCV_LSU_TIMEOUT_EN to abort stuck accesses with bus_err
// after TIMEOUT cycles in REQ+WAIT; without it bus_err is tied low.
//
// Handshake: the core holds req_valid and its request fields stable while
// stall=1 and must advance in the cycle it sees resp_valid. Towards memory,
// mem_req and its qualifiers are held until mem_gnt; mem_rvalid/mem_gnt seen
// outside REQ/WAIT are ignored. The internal state is state_q (lsu_state_t).
module riscv_lsu #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic [2:0]          req_funct3,
    input  logic [DATA_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                stall,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                misalign,
    output logic                bus_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

    lsu_state_t        state_q, state_d;
    logic              cap_write;
    logic [2:0]        cap_funct3;
    logic [1:0]        cap_lane;
    logic              req_bad;
    logic              timeout_hit;
    logic              fin_data, fin_mis, fin_err;
    logic [BE_W-1:0]   be_d;
    logic [DATA_W-1:0] wdata_d;
    logic [DATA_W-1:0] load_ext;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic              unused_addr;

    assign unused_addr = ^req_addr[DATA_W-1:ADDR_W+2];

    assign stall = req_valid & ~resp_valid;

    // Classify the incoming request: illegal funct3 or misaligned address.
    always_comb begin
        req_bad = 1'b0;
        if (req_write) begin
            case (req_funct3)
                3'd0:    req_bad = 1'b0;
                3'd1:    req_bad = req_addr[0];
                3'd2:    req_bad = (req_addr[1:0] != 2'b00);
                default: req_bad = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'd0, 3'd4: req_bad = 1'b0;
                3'd1, 3'd5: req_bad = req_addr[0];
                3'd2:       req_bad = (req_addr[1:0] != 2'b00);
                default:    req_bad = 1'b1;
            endcase
        end
    end

    // Byte enables and lane-replicated store data for the incoming request.
    always_comb begin
        be_d    = '1;
        wdata_d = '0;
        if (req_write) begin
            wdata_d = req_wdata;
            case (req_funct3[1:0])
                2'b00: begin
                    be_d    = BE_W'(1) << req_addr[1:0];
                    wdata_d = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    be_d    = BE_W'(3) << {req_addr[1], 1'b0};
                    wdata_d = {2{req_wdata[15:0]}};
                end
                default: be_d = '1;
            endcase
        end
    end

    // Select the addressed byte/halfword of the returned word and extend it.
    always_comb begin
        sel_byte = mem_rdata[8*cap_lane +: 8];
        sel_half = mem_rdata[16*cap_lane[1] +: 16];
        case (cap_funct3)
            3'd0:    load_ext = {{24{sel_byte[7]}}, sel_byte};
            3'd4:    load_ext = {24'd0, sel_byte};
            3'd1:    load_ext = {{16{sel_half[15]}}, sel_half};
            3'd5:    load_ext = {16'd0, sel_half};
            3'd2:    load_ext = mem_rdata;
            default: load_ext = '0;
        endcase
    end

    // Next-state logic and completion classification.
    always_comb begin
        state_d  = state_q;
        fin_data = 1'b0;
        fin_mis  = 1'b0;
        fin_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_bad) begin
                        state_d = DONE;
                        fin_mis = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    if (cap_write) begin
                        state_d = DONE;
                    end else if (mem_rvalid) begin
                        state_d  = DONE;
                        fin_data = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (timeout_hit) begin
                    state_d = DONE;
                    fin_err = 1'b1;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d  = DONE;
                    fin_data = 1'b1;
                end else if (timeout_hit) begin
                    state_d = DONE;
                    fin_err = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, request capture and registered memory/response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cap_write  <= 1'b0;
            cap_funct3 <= 3'd0;
            cap_lane   <= 2'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            misalign   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                cap_write  <= req_write;
                cap_funct3 <= req_funct3;
                cap_lane   <= req_addr[1:0];
            end
            mem_req <= (state_d == REQ);
            if (state_q == IDLE && state_d == REQ) begin
                mem_we    <= req_write;
                mem_addr  <= req_addr[ADDR_W+1:2];
                mem_be    <= be_d;
                mem_wdata <= wdata_d;
            end else if (state_d != REQ) begin
                mem_we    <= 1'b0;
                mem_addr  <= '0;
                mem_be    <= '0;
                mem_wdata <= '0;
            end
            resp_valid <= (state_d == DONE);
            resp_rdata <= fin_data ? load_ext : '0;
            misalign   <= fin_mis;
        end
    end

`ifdef RISCV_LSU_TIMEOUT_EN
    logic [7:0] cnt_q;

    assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

    // Cycle counter for REQ+WAIT, restarted on every entry to REQ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else if (state_q == IDLE && state_d == REQ) begin
            cnt_q <= 8'd0;
        end else if (state_q == REQ || state_q == WAIT) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    // Registered bus error flag, high only alongside resp_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_err <= 1'b0;
        end else begin
            bus_err <= fin_err;
        end
    end
`else
    logic unused_err;

    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
    assign unused_err  = fin_err;
`endif

endmodule
